// File: rtl/sample_capture.sv
// Pre-trigger capture stage: records a window of samples around an amplitude trigger
// into a circular RAM, then replays it oldest-first as one contiguous valid/data burst.
module sample_capture #(
  parameter int SAMPLE_DATA_WIDTH = 8,
  parameter int CAPTURE_LENGTH    = 1000,
  parameter int PRETRIGGER        = 64,
  parameter int THRESHOLD         = 20
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         arm,
  input  logic                         axiiv,
  input  logic [SAMPLE_DATA_WIDTH-1:0] axiid,
  output logic                         axiov,
  output logic [SAMPLE_DATA_WIDTH-1:0] axiod,
  output logic                         axiol,
  output logic                         busy,
  output logic                         triggered
);

  localparam int W  = SAMPLE_DATA_WIDTH;
  localparam int TW = W + 1;
  localparam int AW = (CAPTURE_LENGTH > 1) ? $clog2(CAPTURE_LENGTH) : 1;
  localparam int CW = $clog2(CAPTURE_LENGTH + 1);

  localparam logic [W-1:0]  MID       = {1'b1, {(W-1){1'b0}}};
  localparam logic [TW-1:0] THR       = TW'(THRESHOLD);
  localparam logic [AW-1:0] LAST_ADDR = AW'(CAPTURE_LENGTH - 1);
  localparam logic [CW-1:0] PRE_CNT   = CW'(PRETRIGGER);
  localparam logic [CW-1:0] POST_CNT  = CW'(CAPTURE_LENGTH - PRETRIGGER);
  localparam logic [CW-1:0] LAST_READ = CW'(CAPTURE_LENGTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_ARMED,
    S_POST,
    S_READOUT,
    S_DRAIN
  } state_t;

  state_t state, state_next;

  logic [W-1:0]  mem [CAPTURE_LENGTH];
  logic [AW-1:0] wp, rp, wp_inc, rp_inc;
  logic [CW-1:0] fc, pc, rc;
  logic [W-1:0]  mag;
  logic          hit;
  logic          we, trig_hit, latch_rp, read_en;

  assign mag    = (axiid >= MID) ? (axiid - MID) : (MID - axiid);
  assign hit    = {1'b0, mag} >= THR;
  assign wp_inc = (wp == LAST_ADDR) ? '0 : wp + AW'(1);
  assign rp_inc = (rp == LAST_ADDR) ? '0 : rp + AW'(1);
  assign busy   = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    we         = 1'b0;
    trig_hit   = 1'b0;
    latch_rp   = 1'b0;
    read_en    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (arm) state_next = S_FILL;
      end
      S_FILL: begin
        if (axiiv) begin
          we = 1'b1;
          if (fc + CW'(1) == PRE_CNT) state_next = S_ARMED;
        end
      end
      S_ARMED: begin
        if (axiiv) begin
          we = 1'b1;
          if (hit) begin
            trig_hit = 1'b1;
            // A one-sample post window is already complete with the trigger itself.
            if (POST_CNT == CW'(1)) begin
              latch_rp   = 1'b1;
              state_next = S_READOUT;
            end else begin
              state_next = S_POST;
            end
          end
        end
      end
      S_POST: begin
        if (axiiv) begin
          we = 1'b1;
          if (pc + CW'(1) == POST_CNT) begin
            latch_rp   = 1'b1;
            state_next = S_READOUT;
          end
        end
      end
      S_READOUT: begin
        read_en = 1'b1;
        if (rc == LAST_READ) state_next = S_DRAIN;
      end
      S_DRAIN: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (we) mem[wp] <= axiid;
  end

  // Once the window closes, the slot after the newest sample holds the oldest one.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp        <= '0;
      rp        <= '0;
      fc        <= '0;
      pc        <= '0;
      rc        <= '0;
      triggered <= 1'b0;
      axiov     <= 1'b0;
      axiol     <= 1'b0;
      axiod     <= '0;
    end else begin
      triggered <= trig_hit;
      axiov     <= read_en;
      axiol     <= read_en && (rc == LAST_READ);
      if (read_en) axiod <= mem[rp];
      if (we) wp <= wp_inc;
      if (state == S_IDLE && arm) begin
        fc <= '0;
      end else if (state == S_FILL && axiiv) begin
        fc <= fc + CW'(1);
      end
      if (trig_hit) begin
        pc <= CW'(1);
      end else if (state == S_POST && axiiv) begin
        pc <= pc + CW'(1);
      end
      if (latch_rp) begin
        rp <= wp_inc;
        rc <= '0;
      end else if (read_en) begin
        rp <= rp_inc;
        rc <= rc + CW'(1);
      end
    end
  end

endmodule
